regfile_param: RTL and testbench

Parametrised multi-port register file: DEPTH registers of WIDTH bits, one synchronous write port, two combinational read ports, and register 0 hardwired to zero. It replaces the fixed 8x8 bank in the datapath. It adds a sequenced hardware clear engine with a busy/done handshake, and a compile-time write-to-read bypass.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_param_register_n.sv | 24 ++
 rtl/regfile_param.sv | 112 +++++++++++
 tb/tb_regfile_param.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional write-to-read bypass is selected by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 8;
  localparam int REGFILE_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clear_state_t;

  function automatic logic is_zero_addr(input int unsigned addr);
    return addr == 0;
  endfunction

endpackage

// File: rtl/regfile_param_register_n.sv
// Single WIDTH-bit storage register with async reset, load enable and sync clear.
// Synchronous clear wins over load so a sweep always leaves the register zero.
module register_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: one write port, two combinational read ports, r0 == 0,
// sequenced clear engine. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH,
  parameter int DEPTH = REGFILE_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_enable,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  output logic             write_ready,
  input  logic [AW-1:0]    reg_addr_1,
  input  logic [AW-1:0]    reg_addr_2,
  output logic [WIDTH-1:0] reg_data_1,
  output logic [WIDTH-1:0] reg_data_2,
  input  logic             clear_req,
  output logic             clear_busy,
  output logic             clear_done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clear_state_t state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic write_accept;
  logic [WIDTH-1:0] regs [DEPTH];

  assign write_ready  = (state == IDLE);
  assign clear_busy   = (state != IDLE);
  assign clear_done   = (state == DONE);
  assign write_accept = write_enable && write_ready && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= AW'(1);
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Sweep walks ptr from 1 up to DEPTH-1, one register per edge, then a single DONE cycle.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          ptr_next   = AW'(1);
        end
      end
      CLEAR: begin
        if (ptr == LAST_ADDR) begin
          state_next = DONE;
          ptr_next   = AW'(1);
        end else begin
          ptr_next = ptr + AW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        ptr_next   = AW'(1);
      end
    endcase
  end

  // Register 0 is a constant; writes to it simply have no destination.
  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic load;
    logic clear;
    logic [WIDTH-1:0] q;

    assign load  = write_accept && !is_zero_addr(int'(write_addr)) && (write_addr == AW'(i));
    assign clear = (state == CLEAR) && (ptr == AW'(i));

    register_n #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .clear(clear),
      .d    (write_data),
      .q    (q)
    );

    assign regs[i] = q;
  end

  always_comb begin
    reg_data_1 = regs[reg_addr_1];
    reg_data_2 = regs[reg_addr_2];
`ifdef REGFILE_BYPASS_EN
    if (write_accept && !is_zero_addr(int'(write_addr))) begin
      if (reg_addr_1 == write_addr) reg_data_1 = write_data;
      if (reg_addr_2 == write_addr) reg_data_2 = write_data;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (WIDTH=8, DEPTH=8) against a cycle-level reference model.
// Honours REGFILE_BYPASS_EN when computing expected read data.
module tb_regfile_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             write_enable;
  logic [AW-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic             write_ready;
  logic [AW-1:0]    reg_addr_1;
  logic [AW-1:0]    reg_addr_2;
  logic [WIDTH-1:0] reg_data_1;
  logic [WIDTH-1:0] reg_data_2;
  logic             clear_req;
  logic             clear_busy;
  logic             clear_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: register contents plus sweep position (0 idle, 1..DEPTH-1 clearing, DEPTH done).
  logic [WIDTH-1:0] model [DEPTH];
  int sweep_pos;

  regfile_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_ready (write_ready),
    .reg_addr_1  (reg_addr_1),
    .reg_addr_2  (reg_addr_2),
    .reg_data_1  (reg_data_1),
    .reg_data_2  (reg_data_2),
    .clear_req   (clear_req),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_read(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = (a == 0) ? '0 : model[a];
`ifdef REGFILE_BYPASS_EN
    if (!rst && write_enable && sweep_pos == 0 && write_addr != 0 && write_addr == a) v = write_data;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    sweep_pos = 0;
  endtask

  // Advance the model by one edge using the inputs currently applied, then let the DUT take the edge.
  task automatic tick();
    if (rst) begin
      model_reset();
    end else begin
      if (sweep_pos == 0 && write_enable && write_addr != 0) model[write_addr] = write_data;
      if (sweep_pos == 0) begin
        if (clear_req) sweep_pos = 1;
      end else if (sweep_pos < DEPTH) begin
        model[sweep_pos] = '0;
        sweep_pos++;
      end else begin
        sweep_pos = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0;
    write_addr   = '0;
    write_data   = '0;
    clear_req    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    reg_addr_1 = 3'd3;
    reg_addr_2 = 3'd7;
    tick();
    tick();
    tests_run++;
    if (write_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_write_ready got %0b want 1", write_ready);
    end
    tests_run++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_clear got busy=%0b done=%0b want 0/0", clear_busy, clear_done);
    end
    tests_run++;
    if (reg_data_1 !== 8'h00 || reg_data_2 !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_read got %h/%h want 00/00", reg_data_1, reg_data_2);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_write_read();
    // Directed: 0xA5 to r3, visible next cycle.
    write_enable = 1'b1; write_addr = 3'd3; write_data = 8'hA5;
    tick();
    idle_inputs();
    reg_addr_1 = 3'd3;
    #1;
    tests_run++;
    if (reg_data_1 !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL write_r3 got %h want a5", reg_data_1);
    end
    // Directed: write to r0 is discarded.
    write_enable = 1'b1; write_addr = 3'd0; write_data = 8'hFF;
    tick();
    idle_inputs();
    reg_addr_1 = 3'd0; reg_addr_2 = 3'd0;
    #1;
    tests_run++;
    if (reg_data_1 !== 8'h00 || reg_data_2 !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL write_r0 got %h/%h want 00/00", reg_data_1, reg_data_2);
    end
    // Random writes and reads, checked every cycle before the edge.
    for (int n = 0; n < 40; n++) begin
      write_enable = 1'($urandom);
      write_addr   = AW'($urandom);
      write_data   = WIDTH'($urandom);
      reg_addr_1   = AW'($urandom);
      reg_addr_2   = (n % 4 == 0) ? write_addr : AW'($urandom);
      #1;
      tests_run++;
      if (reg_data_1 !== exp_read(reg_addr_1) || reg_data_2 !== exp_read(reg_addr_2)) begin
        tests_failed++;
        $display("[TB] FAIL rand_read addr %0d/%0d got %h/%h want %h/%h", reg_addr_1, reg_addr_2,
                 reg_data_1, reg_data_2, exp_read(reg_addr_1), exp_read(reg_addr_2));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] want;
    write_enable = 1'b1; write_addr = 3'd5; write_data = 8'h01;
    tick();
    write_data = 8'h3C;
    reg_addr_2 = 3'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 8'h3C;
`else
    want = 8'h01;
`endif
    tests_run++;
    if (reg_data_2 !== want) begin
      tests_failed++;
      $display("[TB] FAIL bypass_same_cycle got %h want %h", reg_data_2, want);
    end
    tick();
    idle_inputs();
    #1;
    tests_run++;
    if (reg_data_2 !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL bypass_next_cycle got %h want 3c", reg_data_2);
    end
  endtask

  task automatic fill_regs();
    for (int i = 1; i < DEPTH; i++) begin
      write_enable = 1'b1;
      write_addr   = AW'(i);
      write_data   = WIDTH'(i * 8'h11);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    fill_regs();
    reg_addr_1 = 3'd1;
    reg_addr_2 = 3'd7;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    // k counts edges after the sampling edge N.
    for (int k = 0; k <= DEPTH; k++) begin
      if (k == 3) begin
        write_enable = 1'b1; write_addr = 3'd2; write_data = 8'h42;
      end else begin
        write_enable = 1'b0;
      end
      #1;
      tests_run++;
      if (clear_busy !== (sweep_pos != 0) || clear_done !== (sweep_pos == DEPTH) ||
          write_ready !== (sweep_pos == 0)) begin
        tests_failed++;
        $display("[TB] FAIL sweep_ctrl N+%0d got busy=%0b done=%0b ready=%0b want %0b/%0b/%0b", k,
                 clear_busy, clear_done, write_ready, sweep_pos != 0, sweep_pos == DEPTH, sweep_pos == 0);
      end
      tests_run++;
      if (reg_data_1 !== exp_read(3'd1) || reg_data_2 !== exp_read(3'd7)) begin
        tests_failed++;
        $display("[TB] FAIL sweep_read N+%0d got r1=%h r7=%h want %h/%h", k,
                 reg_data_1, reg_data_2, exp_read(3'd1), exp_read(3'd7));
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      reg_addr_1 = AW'(i);
      #1;
      tests_run++;
      if (reg_data_1 !== 8'h00) begin
        tests_failed++;
        $display("[TB] FAIL sweep_final r%0d got %h want 00", i, reg_data_1);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_regs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0 || write_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_rst_ctrl got busy=%0b done=%0b ready=%0b want 0/0/1",
               clear_busy, clear_done, write_ready);
    end
    for (int i = 1; i < DEPTH; i++) begin
      reg_addr_1 = AW'(i);
      #0.1;
      tests_run++;
      if (reg_data_1 !== 8'h00) begin
        tests_failed++;
        $display("[TB] FAIL async_rst_r%0d got %h want 00", i, reg_data_1);
      end
    end
    model_reset();
    #0.5;
    rst = 1'b0;
    write_enable = 1'b1; write_addr = 3'd6; write_data = 8'h99;
    tick();
    idle_inputs();
    reg_addr_1 = 3'd6;
    #1;
    tests_run++;
    if (reg_data_1 !== 8'h99) begin
      tests_failed++;
      $display("[TB] FAIL post_rst_write got %h want 99", reg_data_1);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int idle_between;
    dones = 0;
    idle_between = 0;
    clear_req = 1'b1;
    for (int n = 0; n < 2 * DEPTH + 4; n++) begin
      tick();
      tests_run++;
      if (clear_busy !== (sweep_pos != 0) || clear_done !== (sweep_pos == DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_ctrl cycle %0d got busy=%0b done=%0b want %0b/%0b", n,
                 clear_busy, clear_done, sweep_pos != 0, sweep_pos == DEPTH);
      end
      if (clear_done === 1'b1) dones++;
      if (dones == 1 && clear_busy === 1'b0) idle_between++;
    end
    clear_req = 1'b0;
    tests_run++;
    if (dones < 2 || idle_between !== 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle_gap got dones=%0d idle=%0d want >=2 and 1", dones, idle_between);
    end
    tick();
    tick();
  endtask

  initial begin
    model_reset();
    reg_addr_1 = '0;
    reg_addr_2 = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_bypass();
    test_sweep();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
